// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// =============================================================================
// Module  : pipe_hazard_ctrl
// Brief   : stall/flush sequencer for the 5-stage rv32i pipeline; define
//           PIPE_PERF_CNT_EN to add the stall/flush/load-use counters.
// Revision: 1.0
// =============================================================================
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 0,
  parameter int TMO_W       = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        imem_req,
  input  logic        imem_resp,
  input  logic        dmem_req,
  input  logic        dmem_resp,
  input  logic        ex_br_taken,
  input  logic        ex_is_load,
  input  logic [4:0]  ex_rd,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  output logic        pc_load,
  output logic        if_id_load,
  output logic        if_id_flush,
  output logic        id_ex_load,
  output logic        id_ex_flush,
  output logic        ex_mem_load,
  output logic        mem_wb_load,
  output logic        mem_wb_flush,
`ifdef PIPE_PERF_CNT_EN
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_events,
  output logic [31:0] lu_stalls,
`endif
  output logic        drop_pending,
  output logic        mem_timeout
);

  typedef enum logic [0:0] {RUN = 1'b0, MEM_WAIT = 1'b1} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [TMO_W-1:0]   r_wait_cnt;
  logic [TMO_W-1:0]   w_cnt_inc;
  logic               w_mem_busy;
  logic               w_fetch_busy;
  logic               w_lu_haz;
  logic               w_br_acc;
  logic               w_lu_decide;

  assign w_mem_busy   = dmem_req & ~dmem_resp;
  assign w_fetch_busy = imem_req & ~imem_resp & ~drop_pending;
  assign w_lu_haz     = ex_is_load & (ex_rd != 5'd0) &
                        ((id_use_rs1 & (id_rs1 == ex_rd)) |
                         (id_use_rs2 & (id_rs2 == ex_rd)));
  assign w_cnt_inc    = (r_wait_cnt == {TMO_W{1'b1}}) ? r_wait_cnt : r_wait_cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) r_state <= RUN;
    else     r_state <= w_state_nxt;
  end

  // Stall/flush decision in priority order; a stalled branch stays in EX.
  always_comb begin
    w_state_nxt  = r_state;
    pc_load      = 1'b1;
    if_id_load   = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_load   = 1'b1;
    id_ex_flush  = 1'b0;
    ex_mem_load  = 1'b1;
    mem_wb_load  = 1'b1;
    mem_wb_flush = 1'b0;
    w_br_acc     = 1'b0;
    w_lu_decide  = 1'b0;

    case (r_state)
      RUN:      if (w_mem_busy) w_state_nxt = MEM_WAIT;
      MEM_WAIT: if (dmem_resp)  w_state_nxt = RUN;
      default:  w_state_nxt = RUN;
    endcase

    if (rst) begin
      pc_load     = 1'b0;
      if_id_load  = 1'b0;
      id_ex_load  = 1'b0;
      ex_mem_load = 1'b0;
      mem_wb_load = 1'b0;
    end else if (w_mem_busy) begin
      pc_load      = 1'b0;
      if_id_load   = 1'b0;
      id_ex_load   = 1'b0;
      ex_mem_load  = 1'b0;
      mem_wb_flush = 1'b1;
    end else if (ex_br_taken) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      w_br_acc    = 1'b1;
    end else if (drop_pending | w_fetch_busy | w_lu_haz) begin
      pc_load     = 1'b0;
      if_id_load  = 1'b0;
      id_ex_flush = 1'b1;
      w_lu_decide = ~drop_pending & ~w_fetch_busy;
    end
  end

  // A redirect with a fetch still in flight must discard that fetch's response.
  always_ff @(posedge clk) begin
    if (rst)
      drop_pending <= 1'b0;
    else if (w_br_acc & (drop_pending | (imem_req & ~imem_resp)))
      drop_pending <= 1'b1;
    else if (drop_pending & imem_resp)
      drop_pending <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst)
      r_wait_cnt <= '0;
    else if ((r_state == MEM_WAIT) && !dmem_resp)
      r_wait_cnt <= w_cnt_inc;
    else
      r_wait_cnt <= '0;
  end

  generate
    if (MEM_TIMEOUT != 0) begin : g_tmo
      always_ff @(posedge clk) begin
        if (rst)
          mem_timeout <= 1'b0;
        else if ((r_state == MEM_WAIT) && (w_cnt_inc == TMO_W'(MEM_TIMEOUT)))
          mem_timeout <= 1'b1;
      end
    end else begin : g_no_tmo
      always_ff @(posedge clk) mem_timeout <= 1'b0;
    end
  endgenerate

`ifdef PIPE_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= 32'd0;
      flush_events <= 32'd0;
      lu_stalls    <= 32'd0;
    end else begin
      if (!pc_load)    stall_cycles <= stall_cycles + 32'd1;
      if (w_br_acc)    flush_events <= flush_events + 32'd1;
      if (w_lu_decide) lu_stalls    <= lu_stalls + 32'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// =============================================================================
// Module  : tb_pipe_hazard_ctrl
// Brief   : directed and randomized checks of pipe_hazard_ctrl against a
//           cause-table reference model.
// Revision: 1.0
// =============================================================================
module tb_pipe_hazard_ctrl;
  localparam int TMO = 3;
  localparam int C_RST = 0, C_MEM = 1, C_BR = 2, C_DROP = 3, C_FETCH = 4, C_LU = 5, C_NONE = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, imem_req, imem_resp, dmem_req, dmem_resp, ex_br_taken, ex_is_load;
  logic [4:0] ex_rd, id_rs1, id_rs2;
  logic       id_use_rs1, id_use_rs2;
  logic       pc_load, if_id_load, if_id_flush, id_ex_load, id_ex_flush;
  logic       ex_mem_load, mem_wb_load, mem_wb_flush, drop_pending, mem_timeout;
`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_cycles, flush_events, lu_stalls;
  logic [31:0] obs_stall, obs_flush, obs_lu;
`endif

  pipe_hazard_ctrl #(.MEM_TIMEOUT(TMO), .TMO_W(16)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_resp(imem_resp),
    .dmem_req(dmem_req), .dmem_resp(dmem_resp), .ex_br_taken(ex_br_taken),
    .ex_is_load(ex_is_load), .ex_rd(ex_rd), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .pc_load(pc_load), .if_id_load(if_id_load), .if_id_flush(if_id_flush),
    .id_ex_load(id_ex_load), .id_ex_flush(id_ex_flush), .ex_mem_load(ex_mem_load),
    .mem_wb_load(mem_wb_load), .mem_wb_flush(mem_wb_flush),
`ifdef PIPE_PERF_CNT_EN
    .stall_cycles(stall_cycles), .flush_events(flush_events), .lu_stalls(lu_stalls),
`endif
    .drop_pending(drop_pending), .mem_timeout(mem_timeout)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference state: pending-drop flag, wait-phase tracking, sticky timeout, counters.
  bit          m_drop, m_wait, m_tmo;
  int          m_cnt;
  logic [31:0] m_stall, m_flush, m_lu;
  logic [7:0]  obs_ctrl;
  logic        obs_drop, obs_tmo;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int cause();
    if (rst) return C_RST;
    if (dmem_req && !dmem_resp) return C_MEM;
    if (ex_br_taken) return C_BR;
    if (m_drop) return C_DROP;
    if (imem_req && !imem_resp) return C_FETCH;
    if (ex_is_load && ex_rd != 0 &&
        ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd))) return C_LU;
    return C_NONE;
  endfunction

  // {pc, if_id_load, if_id_flush, id_ex_load, id_ex_flush, ex_mem, mem_wb_load, mem_wb_flush}
  function automatic logic [7:0] ctrl_of(input int c);
    case (c)
      C_RST:                return 8'b0000_0000;
      C_MEM:                return 8'b0000_0011;
      C_BR:                 return 8'b1111_1110;
      C_DROP, C_FETCH, C_LU: return 8'b0001_1110;
      default:              return 8'b1101_0110;
    endcase
  endfunction

  task automatic cycle();
    int c;
    logic [7:0] e;
    @(negedge clk);
    c = cause();
    e = ctrl_of(c);
    obs_ctrl = {pc_load, if_id_load, if_id_flush, id_ex_load, id_ex_flush,
                ex_mem_load, mem_wb_load, mem_wb_flush};
    obs_drop = drop_pending;
    obs_tmo  = mem_timeout;
    chk("ctrl", obs_ctrl, e);
    chk("drop_pending", obs_drop, m_drop);
    chk("mem_timeout", obs_tmo, m_tmo);
`ifdef PIPE_PERF_CNT_EN
    obs_stall = stall_cycles; obs_flush = flush_events; obs_lu = lu_stalls;
    chk("stall_cycles", obs_stall, m_stall);
    chk("flush_events", obs_flush, m_flush);
    chk("lu_stalls", obs_lu, m_lu);
`endif
    @(posedge clk);
    if (rst) begin
      m_drop = 0; m_wait = 0; m_cnt = 0; m_tmo = 0;
      m_stall = 0; m_flush = 0; m_lu = 0;
    end else begin
      if (c == C_BR && (m_drop || (imem_req && !imem_resp))) m_drop = 1;
      else if (m_drop && imem_resp) m_drop = 0;
      if (!m_wait) begin
        if (c == C_MEM) m_wait = 1;
      end else begin
        if (m_cnt < 65535) m_cnt++;
        if (m_cnt == TMO) m_tmo = 1;
        if (dmem_resp) begin m_wait = 0; m_cnt = 0; end
      end
      if (!e[7]) m_stall = m_stall + 32'd1;
      if (c == C_BR) m_flush = m_flush + 32'd1;
      if (c == C_LU) m_lu = m_lu + 32'd1;
    end
    #1;
  endtask

  task automatic idle_inputs();
    rst = 0; imem_req = 0; imem_resp = 0; dmem_req = 0; dmem_resp = 0;
    ex_br_taken = 0; ex_is_load = 0; ex_rd = 0; id_rs1 = 0; id_rs2 = 0;
    id_use_rs1 = 0; id_use_rs2 = 0;
  endtask

  task automatic do_reset();
    idle_inputs(); rst = 1;
    cycle(); cycle();
    chk("reset_ctrl", obs_ctrl, 8'h00);
    chk("reset_drop", obs_drop, 1'b0);
    chk("reset_tmo", obs_tmo, 1'b0);
    rst = 0;
  endtask

  initial begin
    m_drop = 0; m_wait = 0; m_tmo = 0; m_cnt = 0;
    m_stall = 0; m_flush = 0; m_lu = 0;
    idle_inputs();
    do_reset();

    // Redirect during an in-flight fetch.
    imem_req = 1;
    for (int i = 0; i < 8; i++) begin
      ex_br_taken = (i == 3);
      imem_resp   = (i == 6);
      if (i == 7) imem_req = 0;
      cycle();
      if (i == 3) chk("redir_ctrl", obs_ctrl, 8'b1111_1110);
      if (i >= 4 && i <= 6) begin
        chk("redir_drop", obs_drop, 1'b1);
        chk("redir_ifid_hold", obs_ctrl[6], 1'b0);
      end
      if (i == 7) chk("redir_drop_clr", obs_drop, 1'b0);
    end
    idle_inputs();

    // Load-use: one bubble, then defaults; x0 never hazards.
    ex_is_load = 1; ex_rd = 5; id_rs1 = 5; id_use_rs1 = 1;
    cycle(); chk("lu_stall", obs_ctrl, 8'b0001_1110);
    ex_is_load = 0;
    cycle(); chk("lu_release", obs_ctrl, 8'b1101_0110);
`ifdef PIPE_PERF_CNT_EN
    chk("perf_flush", obs_flush, 32'd1);
    chk("perf_lu", obs_lu, 32'd1);
    chk("perf_stall", obs_stall, 32'd7);
`endif
    ex_is_load = 1; ex_rd = 0; id_rs1 = 0;
    cycle(); chk("lu_x0", obs_ctrl, 8'b1101_0110);
    idle_inputs();

    // Data stall with a branch waiting in EX.
    dmem_req = 1; ex_br_taken = 1;
    for (int i = 0; i < 4; i++) begin
      cycle(); chk("dstall_ctrl", obs_ctrl, 8'b0000_0011);
    end
    dmem_resp = 1;
    cycle(); chk("dstall_br_resp", obs_ctrl, 8'b1111_1110);
    idle_inputs();
    do_reset();

    // Timeout: sticky after the third wait cycle, cleared only by rst.
    dmem_req = 1;
    for (int i = 0; i < 6; i++) begin
      cycle(); chk("tmo_seq", obs_tmo, (i >= 4) ? 1'b1 : 1'b0);
    end
    dmem_resp = 1;
    cycle(); chk("tmo_at_resp", obs_tmo, 1'b1);
    idle_inputs();
    cycle(); cycle(); chk("tmo_sticky", obs_tmo, 1'b1);
    do_reset();

    // Reset while a drop is pending and the data side is waiting.
    imem_req = 1; ex_br_taken = 1;
    cycle();
    ex_br_taken = 0; dmem_req = 1;
    cycle(); cycle(); chk("mid_drop_set", obs_drop, 1'b1);
    rst = 1;
    cycle(); chk("mid_rst_ctrl", obs_ctrl, 8'h00);
    idle_inputs();
    cycle();
    chk("mid_post_drop", obs_drop, 1'b0);
    chk("mid_post_ctrl", obs_ctrl, 8'b1101_0110);
    dmem_resp = 1;
    cycle(); chk("mid_run_state", obs_ctrl, 8'b1101_0110);
    idle_inputs();

    // Randomized traffic.
    for (int n = 0; n < 4000; n++) begin
      rst         = ($urandom_range(0, 99) < 2);
      imem_req    = ($urandom_range(0, 9) < 7);
      imem_resp   = ($urandom_range(0, 9) < 3);
      dmem_req    = ($urandom_range(0, 9) < 4);
      dmem_resp   = ($urandom_range(0, 9) < 3);
      ex_br_taken = ($urandom_range(0, 9) < 2);
      ex_is_load  = $urandom_range(0, 1);
      ex_rd       = 5'($urandom_range(0, 3));
      id_rs1      = 5'($urandom_range(0, 3));
      id_rs2      = 5'($urandom_range(0, 3));
      id_use_rs1  = $urandom_range(0, 1);
      id_use_rs2  = $urandom_range(0, 1);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire
